int_claim_arbiter: RTL

Priority arbiter and claim/complete controller for external interrupts, placed on the XT_BUS hb slave side between peripheral IRQ lines and the core's machine external interrupt input. It conditions each source as level or rising-edge and latches edges. It selects the highest-priority eligible source above a software threshold and tracks in-service sources. Software claims an ID by bus read and releases it by bus write.

---
 rtl/int_claim_pkg.sv | 14 +
 rtl/int_claim_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/int_claim_pkg.sv
// Bus-side types for the interrupt claim arbiter: the hb slave view and the block select strobes.
package int_claim_pkg;

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] wdata;
  } hb_slave_t;

  typedef struct packed {
    logic wen;
    logic ren;
  } sel_t;

endpackage

// File: rtl/int_claim_arbiter.sv
// External interrupt arbiter: level/edge conditioning, priority selection above a threshold,
// and claim (read) / complete (write) tracking of in-service sources.
module int_claim_arbiter
  import int_claim_pkg::*;
#(
  parameter int INT_NUM = 16
) (
  input  logic               hb_clk,
  input  logic               rst_sync_n,
  input  hb_slave_t          xt_hb,
  input  sel_t               sel,
  output logic [31:0]        rdata,
  input  logic [INT_NUM-1:0] irq_source,
  output logic [26:0]        custom_int_code,
  output logic               mextern_int
);

  localparam logic [2:0] OFF_ENABLE    = 3'd0;
  localparam logic [2:0] OFF_PENDING   = 3'd1;
  localparam logic [2:0] OFF_TRIGGER   = 3'd2;
  localparam logic [2:0] OFF_PRIORITY  = 3'd3;
  localparam logic [2:0] OFF_THRESHOLD = 3'd4;
  localparam logic [2:0] OFF_CLAIM     = 3'd5;

  // sel.wen / sel.ren are single-cycle strobes with no backpressure: a write commits at the
  // edge that samples wen, and a read loads rdata at the edge that samples ren.
  logic [INT_NUM-1:0]   enable_q, enable_d;
  logic [INT_NUM-1:0]   trigger_q, trigger_d;
  logic [2*INT_NUM-1:0] prio_q, prio_d;
  logic [1:0]           thresh_q, thresh_d;
  logic [INT_NUM-1:0]   pending_q, pending_d;
  logic [INT_NUM-1:0]   inservice_q, inservice_d;
  logic [INT_NUM-1:0]   irq_d_q, irq_d_d;
  logic [4:0]           best_id_q, best_id_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [2:0]           addr;
  logic [INT_NUM-1:0]   rise;
  logic [INT_NUM-1:0]   claim_vec;
  logic [INT_NUM-1:0]   complete_vec;
  logic                 best_found;
  logic [1:0]           best_prio;
  logic [31:0]          rd_word;
  logic                 unused_hb;

  assign unused_hb = ^{xt_hb.waddr[31:5], xt_hb.waddr[1:0], xt_hb.wdata};

  always_comb begin
    addr         = xt_hb.waddr[4:2];
    rise         = irq_source & ~irq_d_q;
    irq_d_d      = irq_source;
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (sel.ren && (addr == OFF_CLAIM) && (best_id_q == 5'(i + 1))) claim_vec[i] = 1'b1;
      if (sel.wen && (addr == OFF_CLAIM) && (xt_hb.wdata[4:0] == 5'(i + 1))) complete_vec[i] = 1'b1;
    end

    // Edge sources latch until claimed; level sources just follow the line. A claim in the
    // same cycle as an edge wins, so that edge is lost.
    pending_d = ((trigger_q & (pending_q | (rise & ~inservice_q))) |
                 (~trigger_q & irq_source & ~inservice_q)) & ~claim_vec;
    // Complete is applied after claim so claim+complete of one ID leaves it idle.
    inservice_d = (inservice_q | claim_vec) & ~complete_vec;

    best_found = 1'b0;
    best_prio  = '0;
    best_id_d  = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (pending_q[i] && enable_q[i] && !inservice_q[i] &&
          (prio_q[2*i +: 2] > thresh_q) &&
          (!best_found || (prio_q[2*i +: 2] > best_prio))) begin
        best_found = 1'b1;
        best_prio  = prio_q[2*i +: 2];
        best_id_d  = 5'(i + 1);
      end
    end

    enable_d  = enable_q;
    trigger_d = trigger_q;
    prio_d    = prio_q;
    thresh_d  = thresh_q;
    if (sel.wen) begin
      case (addr)
        OFF_ENABLE:    enable_d  = xt_hb.wdata[INT_NUM-1:0];
        OFF_TRIGGER:   trigger_d = xt_hb.wdata[INT_NUM-1:0];
        OFF_PRIORITY:  prio_d    = xt_hb.wdata[2*INT_NUM-1:0];
        OFF_THRESHOLD: thresh_d  = xt_hb.wdata[1:0];
        default: ;
      endcase
    end

    rd_word = '0;
    case (addr)
      OFF_ENABLE:    rd_word[INT_NUM-1:0]   = enable_q;
      OFF_PENDING:   rd_word[INT_NUM-1:0]   = pending_q;
      OFF_TRIGGER:   rd_word[INT_NUM-1:0]   = trigger_q;
      OFF_PRIORITY:  rd_word[2*INT_NUM-1:0] = prio_q;
      OFF_THRESHOLD: rd_word[1:0]           = thresh_q;
      OFF_CLAIM:     rd_word[4:0]           = best_id_q;
      default: ;
    endcase
    rdata_d = sel.ren ? rd_word : rdata_q;
  end

  always_ff @(posedge hb_clk) begin
    if (!rst_sync_n) begin
      enable_q    <= '0;
      trigger_q   <= '0;
      prio_q      <= '0;
      thresh_q    <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      irq_d_q     <= '0;
      best_id_q   <= '0;
      rdata_q     <= '0;
    end else begin
      enable_q    <= enable_d;
      trigger_q   <= trigger_d;
      prio_q      <= prio_d;
      thresh_q    <= thresh_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      irq_d_q     <= irq_d_d;
      best_id_q   <= best_id_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata           = rdata_q;
  assign custom_int_code = {22'b0, best_id_q};
  assign mextern_int     = (best_id_q != 5'd0);

endmodule
